// File: rtl/apb_arb_pkg.sv
// Shared types and default parameters for the APB master arbiter.
// Holds the transfer state enum and the one-hot to index helper.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

    localparam int DEF_NB_REQ         = 2;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int MAX_NB_REQ         = 8;

    function automatic logic [2:0] onehot_to_idx(input logic [MAX_NB_REQ-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_NB_REQ; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_arb_rr.sv
// Round-robin picker: first requester at or above ptr (wrapping) wins.
// Latency: combinational, no state.
// Backpressure: none; valid is low when no requester is asserting.
module apb_arb_rr #(
    parameter int NB_REQ = 2
) (
    input  logic [NB_REQ-1:0]         req,
    input  logic [$clog2(NB_REQ)-1:0] ptr,
    output logic [NB_REQ-1:0]         grant,
    output logic                      valid
);

    localparam int PTR_W = $clog2(NB_REQ);

    logic [PTR_W-1:0] k;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            k = PTR_W'((int'(ptr) + i) % NB_REQ);
            if (!valid && req[k]) begin
                grant[k] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// N-requester APB arbiter driving one downstream APB bus, one transfer at a time.
// Latency: request sampled in cycle 0 -> requester PREADY in cycle 3 with a zero-wait peripheral.
// Backpressure: losers and the owner wait on PREADY; APB_ARB_TIMEOUT_EN adds an ACCESS watchdog.
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int NB_REQ         = DEF_NB_REQ,
    parameter int APB_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int APB_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NB_REQ-1:0]                  req_psel_i,
    input  logic [NB_REQ-1:0]                  req_penable_i,
    input  logic [NB_REQ-1:0]                  req_pwrite_i,
    input  logic [NB_REQ*APB_ADDR_WIDTH-1:0]   req_paddr_i,
    input  logic [NB_REQ*APB_DATA_WIDTH-1:0]   req_pwdata_i,
    output logic [APB_DATA_WIDTH-1:0]          req_prdata_o,
    output logic [NB_REQ-1:0]                  req_pready_o,
    output logic [NB_REQ-1:0]                  req_pslverr_o,
    output logic                               apb_psel_o,
    output logic                               apb_penable_o,
    output logic                               apb_pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]          apb_paddr_o,
    output logic [APB_DATA_WIDTH-1:0]          apb_pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0]          apb_prdata_i,
    input  logic                               apb_pready_i,
    input  logic                               apb_pslverr_i,
    output logic [NB_REQ-1:0]                  grant_o
);

    localparam int PTR_W = $clog2(NB_REQ);

    arb_state_t                state_q, state_d;
    logic [PTR_W-1:0]          ptr_q;
    logic [NB_REQ-1:0]         grant_q;
    logic [NB_REQ-1:0]         rr_grant;
    logic                      rr_vld;
    logic [APB_ADDR_WIDTH-1:0] addr_q, sel_addr;
    logic [APB_DATA_WIDTH-1:0] wdata_q, sel_wdata;
    logic                      write_q, sel_write;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      slverr_q;
    logic                      timeout;
    logic [MAX_NB_REQ-1:0]     grant_ext;
    logic [2:0]                own_idx;
    logic                      unused_penable;

    // The arbiter only looks at PSEL; requester PENABLE carries no extra information.
    assign unused_penable = ^req_penable_i;

    apb_arb_rr #(.NB_REQ(NB_REQ)) u_rr (
        .req   (req_psel_i),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .valid (rr_vld)
    );

    assign grant_ext = MAX_NB_REQ'(grant_q);
    assign own_idx   = onehot_to_idx(grant_ext);

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt_q;

    // Fires on the ACCESS cycle that would bring the stall count to TIMEOUT_CYCLES.
    assign timeout = (to_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            to_cnt_q <= '0;
        end else if (state_q == ACCESS && !apb_pready_i) begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign timeout        = 1'b0;
`endif

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int k = 0; k < NB_REQ; k++) begin
            if (rr_grant[k]) begin
                sel_addr  = req_paddr_i[k*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                sel_wdata = req_pwdata_i[k*APB_DATA_WIDTH +: APB_DATA_WIDTH];
                sel_write = req_pwrite_i[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rr_vld) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (apb_pready_i || timeout) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            rdata_q  <= '0;
            slverr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_vld) begin
                        grant_q <= rr_grant;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        write_q <= sel_write;
                    end
                end
                ACCESS: begin
                    if (apb_pready_i) begin
                        rdata_q  <= apb_prdata_i;
                        slverr_q <= apb_pslverr_i;
                    end else if (timeout) begin
                        rdata_q  <= '0;
                        slverr_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (int'(own_idx) == NB_REQ - 1) begin
                        ptr_q <= '0;
                    end else begin
                        ptr_q <= PTR_W'(int'(own_idx) + 1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign apb_paddr_o  = addr_q;
    assign apb_pwdata_o = wdata_q;
    assign apb_pwrite_o = write_q;
    assign req_prdata_o = rdata_q;

    always_comb begin
        apb_psel_o    = 1'b0;
        apb_penable_o = 1'b0;
        grant_o       = '0;
        req_pready_o  = '0;
        req_pslverr_o = '0;
        case (state_q)
            SETUP: begin
                apb_psel_o = 1'b1;
                grant_o    = grant_q;
            end
            ACCESS: begin
                apb_psel_o    = 1'b1;
                apb_penable_o = 1'b1;
                grant_o       = grant_q;
            end
            RESP: begin
                grant_o       = grant_q;
                req_pready_o  = grant_q;
                req_pslverr_o = slverr_q ? grant_q : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/apb_master_arb.md
APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 NB_REQ, 2, number of APB requesters (2..8).
REQ-002 APB_ADDR_WIDTH, 32, address width.
REQ-003 APB_DATA_WIDTH, 32, data width.
REQ-004 TIMEOUT_CYCLES, 255, ACCESS-phase abort threshold; used only with APB_ARB_TIMEOUT_EN.
REQ-005 clk_i  input  1  clock; all state on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 req_psel_i  input  NB_REQ  per-requester PSEL.
REQ-008 req_penable_i  input  NB_REQ  per-requester PENABLE.
REQ-009 req_pwrite_i  input  NB_REQ  per-requester PWRITE.
REQ-010 req_paddr_i  input  NB_REQ*APB_ADDR_WIDTH  packed PADDR; requester k at slice k.
REQ-011 req_pwdata_i  input  NB_REQ*APB_DATA_WIDTH  packed PWDATA.
REQ-012 req_prdata_o  output  APB_DATA_WIDTH  shared read data; valid with req_pready_o.
REQ-013 req_pready_o  output  NB_REQ  per-requester PREADY; one-hot or zero.
REQ-014 req_pslverr_o  output  NB_REQ  per-requester PSLVERR; valid with req_pready_o.
REQ-015 apb_psel_o  output  1  downstream PSEL to peripheral bus node.
REQ-016 apb_penable_o  output  1  downstream PENABLE.
REQ-017 apb_pwrite_o  output  1  downstream PWRITE.
REQ-018 apb_paddr_o  output  APB_ADDR_WIDTH  downstream PADDR.
REQ-019 apb_pwdata_o  output  APB_DATA_WIDTH  downstream PWDATA.
REQ-020 apb_prdata_i  input  APB_DATA_WIDTH  downstream PRDATA.
REQ-021 apb_pready_i  input  1  downstream PREADY.
REQ-022 apb_pslverr_i  input  1  downstream PSLVERR.
REQ-023 grant_o  output  NB_REQ  one-hot current owner; zero in IDLE.

Function
REQ-024 The FSM SHALL have the states IDLE, SETUP, ACCESS and RESP, and SHALL carry one downstream transfer at a time.
REQ-025 In IDLE, if any req_psel_i bit is set, the block SHALL pick a winner round-robin from the pointer, register its paddr/pwdata/pwrite and one-hot grant, and go to SETUP; otherwise it SHALL stay in IDLE.
REQ-026 In SETUP, the block SHALL drive apb_psel_o=1 and apb_penable_o=0 for exactly one cycle, then go to ACCESS.
REQ-027 In ACCESS, the block SHALL hold apb_psel_o=1 and apb_penable_o=1 until apb_pready_i=1; on that edge it SHALL capture apb_prdata_i and apb_pslverr_i and go to RESP.
REQ-028 In RESP, for exactly one cycle, the block SHALL drive req_pready_o[grant]=1, req_pslverr_o[grant] and req_prdata_o from the captured values, and downstream psel/penable=0; it SHALL then set pointer=(grant index+1) mod NB_REQ and go to IDLE.
REQ-029 Downstream addr/data/write SHALL come from registers only and stay stable from SETUP through ACCESS; there SHALL be no combinational path from requester to downstream.
REQ-030 With a zero-wait peripheral, req_psel_i sampled in cycle 0 SHALL produce req_pready_o in cycle 3; each transfer SHALL take at least 4 cycles.
REQ-031 Non-granted requesters SHALL see req_pready_o=0 and wait; requests arriving during a transfer SHALL be arbitrated in the next IDLE.
REQ-032 With simultaneous requests, the lowest index at or above the pointer SHALL win; a requester that drops psel before grant SHALL not be considered.
REQ-033 If the granted requester drops psel before RESP, the downstream transfer SHALL still complete and the RESP pulse SHALL still be generated.
REQ-034 Outside RESP, req_prdata_o SHALL hold its last captured value and req_pslverr_o SHALL be 0.

Reset
REQ-035 When rst_i is asserted at any time, including mid-transfer, the block SHALL set state=IDLE, pointer=0, captured data=0 and all outputs=0 asynchronously, and SHALL drop the in-flight transfer without a response.
REQ-036 The block SHALL sample the first request on the first rising edge after rst_i deasserts.

Configuration
REQ-037 With APB_ARB_TIMEOUT_EN defined, a counter SHALL clear on ACCESS entry and increment on each ACCESS cycle with apb_pready_i=0; on reaching TIMEOUT_CYCLES the block SHALL force RESP with req_pslverr_o=1 and req_prdata_o=0, and drop downstream psel/penable.
REQ-038 With APB_ARB_TIMEOUT_EN undefined, the block SHALL have no counter, ACCESS SHALL wait indefinitely for apb_pready_i, and TIMEOUT_CYCLES SHALL be ignored.

Structure
REQ-039 Package apb_arb_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS, RESP) and the default width/timeout constants.
REQ-040 Sub-module apb_arb_rr SHALL be a combinational round-robin picker: request vector + pointer in, one-hot grant + valid out.

Verification
REQ-041 req0 write 0x1A10_0000/0xDEADBEEF, apb_pready_i=1 -> apb_psel_o in cycles 1-2, apb_penable_o in cycle 2, req_pready_o=2'b01 in cycle 3.
REQ-042 req0 and req1 both requesting continuously from reset -> grants alternate 0,1,0,1, each transfer 4 cycles.
REQ-043 Peripheral holds pready=0 for 5 ACCESS cycles, then returns 0x12345678 -> apb_paddr_o stable throughout, req_prdata_o=0x12345678 with a single-cycle req_pready_o.
REQ-044 apb_pslverr_i=1 with pready -> req_pslverr_o[grant]=1 in RESP only; other bits stay 0.
REQ-045 rst_i pulsed mid-ACCESS -> all outputs 0 the same cycle, no req_pready_o; the next request is served normally.
REQ-046 APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> RESP after 16 ACCESS cycles, req_pslverr_o=1, req_prdata_o=0.
